// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the M stage and data memory.
// The stage drives the request side; memory answers with ready/rdata.
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: issues data-memory accesses for the instruction in the
// M register, produces m_valM/m_stat for forwarding, and owns the W register.
// The pipeline stalls (bubbles into W) while an access waits on dmem_ready.
// Optional build macro MEM_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles and
// report it as an address error.
module memory_stage #(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           M_stat,
  input  logic [3:0]           M_icode,
  input  logic                 M_Cnd,
  input  logic [63:0]          M_valE,
  input  logic [63:0]          M_valA,
  input  logic [3:0]           M_destE,
  input  logic [3:0]           M_destM,
  memory_stage_if.master       dmem,
  output logic [63:0]          m_valM,
  output logic [3:0]           m_stat,
  output logic                 m_stall,
  output logic [3:0]           W_stat,
  output logic [3:0]           W_icode,
  output logic [63:0]          W_valE,
  output logic [63:0]          W_valM,
  output logic [3:0]           W_destE,
  output logic [3:0]           W_destM
);

  localparam logic [3:0]  S_AOK    = 4'h1;
  localparam logic [3:0]  S_ADR    = 4'h3;
  localparam logic [3:0]  I_NOP    = 4'h1;
  localparam logic [3:0]  R_NONE   = 4'hF;
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;

  // Condition flag is not needed here; TIMEOUT only matters with the macro.
  logic [1:0] unused_sig;
  assign unused_sig = {M_Cnd, TIMEOUT > 0};

  // Access decode: which instructions touch memory, in which direction, where.
  logic        access, is_read, illegal, suppress, timed_out;
  logic [63:0] addr;

  always_comb begin
    access  = 1'b0;
    is_read = 1'b0;
    addr    = M_valE;
    case (M_icode)
      4'h4, 4'h8, 4'hA: access = 1'b1;
      4'h5:             begin access = 1'b1; is_read = 1'b1; end
      4'h9, 4'hB:       begin access = 1'b1; is_read = 1'b1; addr = M_valA; end
      default:          ;
    endcase
  end

  assign illegal  = access && (addr > ADDR_MAX);
  // Never touch memory once an exception is in M or already in W.
  assign suppress = (M_stat != S_AOK) || (W_stat != S_AOK);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Wait counter: counts WAIT cycles, clears whenever WAIT is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        wait_cnt <= '0;
    else if (state == S_WAIT && state_nxt == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
    else                                               wait_cnt <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: enter WAIT on an unanswered request, leave on ready/drop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (dmem.dmem_req && !dmem.dmem_ready) state_nxt = S_WAIT;
      S_WAIT: if (!dmem.dmem_req || dmem.dmem_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: bus drive, stall, forwarded status and read data.
  // rst_n gates req so an aborted access disappears immediately on reset.
  always_comb begin
    dmem.dmem_req   = rst_n && access && !illegal && !suppress && !timed_out;
    dmem.dmem_we    = access && !is_read;
    dmem.dmem_addr  = addr;
    dmem.dmem_wdata = M_valA;
    m_stall         = dmem.dmem_req && !dmem.dmem_ready;
    m_valM          = (dmem.dmem_req && dmem.dmem_ready && is_read) ? dmem.dmem_rdata : 64'd0;
    m_stat          = (illegal || timed_out) ? S_ADR : M_stat;
  end

  // W pipeline register: bubble while stalled, otherwise take the M result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_destE <= R_NONE;
      W_destM <= R_NONE;
    end else if (m_stall) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_destE <= R_NONE;
      W_destM <= R_NONE;
    end else begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_destE <= M_destE;
      W_destM <= M_destM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus queues expected values tagged
// with the cycle they must hold in; a monitor checks them on the falling edge.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_stat, M_icode, M_destE, M_destM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [63:0] m_valM;
  logic [3:0]  m_stat;
  logic        m_stall;
  logic [3:0]  W_stat, W_icode, W_destE, W_destM;
  logic [63:0] W_valE, W_valM;

  memory_stage_if dif();

  memory_stage #(.MEM_BYTES(8192), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_destE(M_destE), .M_destM(M_destM),
    .dmem(dif),
    .m_valM(m_valM), .m_stat(m_stat), .m_stall(m_stall),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_destE(W_destE), .W_destM(W_destM)
  );

  always #5 clk = ~clk;

  localparam int S_REQ = 0, S_WE = 1, S_ADDR = 2, S_WDATA = 3, S_STALL = 4,
                 S_MSTAT = 5, S_VALM = 6, S_WSTAT = 7, S_WICODE = 8,
                 S_WVALE = 9, S_WVALM = 10, S_WDESTE = 11, S_WDESTM = 12;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] act(input int sel);
    case (sel)
      S_REQ:    act = 64'(dif.dmem_req);
      S_WE:     act = 64'(dif.dmem_we);
      S_ADDR:   act = dif.dmem_addr;
      S_WDATA:  act = dif.dmem_wdata;
      S_STALL:  act = 64'(m_stall);
      S_MSTAT:  act = 64'(m_stat);
      S_VALM:   act = m_valM;
      S_WSTAT:  act = 64'(W_stat);
      S_WICODE: act = 64'(W_icode);
      S_WVALE:  act = W_valE;
      S_WVALM:  act = W_valM;
      S_WDESTE: act = 64'(W_destE);
      S_WDESTM: act = 64'(W_destM);
      default:  act = 64'hx;
    endcase
  endfunction

  // dly 0: must hold this cycle; dly 1: must hold in W after the next edge.
  task automatic chk(input string nm, input int sel, input logic [63:0] e, input int dly);
    chk_t c;
    c.cyc  = cyc + dly;
    c.sel  = sel;
    c.exp  = e;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic exp_w(input string nm, input logic [3:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm, input int dly);
    chk({nm, ".W_stat"},  S_WSTAT,  64'(st), dly);
    chk({nm, ".W_icode"}, S_WICODE, 64'(ic), dly);
    chk({nm, ".W_valE"},  S_WVALE,  ve,      dly);
    chk({nm, ".W_valM"},  S_WVALM,  vm,      dly);
    chk({nm, ".W_destE"}, S_WDESTE, 64'(de), dly);
    chk({nm, ".W_destM"}, S_WDESTM, 64'(dm), dly);
  endtask

  task automatic exp_bubble(input string nm, input int dly);
    chk({nm, ".W_stat"},  S_WSTAT,  64'h1, dly);
    chk({nm, ".W_icode"}, S_WICODE, 64'h1, dly);
    chk({nm, ".W_destE"}, S_WDESTE, 64'hF, dly);
    chk({nm, ".W_destM"}, S_WDESTM, 64'hF, dly);
  endtask

  task automatic set_m(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_destE = de; M_destM = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  initial begin
    chk_t        c;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        c = q.pop_front();
        a = act(c.sel);
        n_chk++;
        if (c.cyc == cyc && a === c.exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, want %h", c.name, cyc, a, c.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    M_Cnd = 1'b1;
    set_m(4'h1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    dif.dmem_ready = 1'b1;
    dif.dmem_rdata = 64'd0;

    // Reset state.
    step();
    exp_w("reset", 4'h1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 0);
    chk("reset.req", S_REQ, 64'd0, 0);

    // mrmovq, zero-wait read.
    step();
    rst_n = 1'b1;
    set_m(4'h1, 4'h5, 64'h100, 64'd0, 4'hF, 4'h3);
    dif.dmem_ready = 1'b1; dif.dmem_rdata = 64'h55;
    chk("mr.req",   S_REQ,   64'd1,    0);
    chk("mr.we",    S_WE,    64'd0,    0);
    chk("mr.addr",  S_ADDR,  64'h100,  0);
    chk("mr.stall", S_STALL, 64'd0,    0);
    chk("mr.valM",  S_VALM,  64'h55,   0);
    exp_w("mr", 4'h1, 4'h5, 64'h100, 64'h55, 4'hF, 4'h3, 1);

    // pushq, ready after 3 wait cycles: 3 bubbles then the push.
    for (int i = 0; i < 4; i++) begin
      step();
      set_m(4'h1, 4'hA, 64'h1F8, 64'hAB, 4'h4, 4'hF);
      dif.dmem_ready = (i == 3); dif.dmem_rdata = 64'hDEAD;
      chk("push.req",   S_REQ,   64'd1,   0);
      chk("push.we",    S_WE,    64'd1,   0);
      chk("push.addr",  S_ADDR,  64'h1F8, 0);
      chk("push.wdata", S_WDATA, 64'hAB,  0);
      chk("push.stall", S_STALL, (i == 3) ? 64'd0 : 64'd1, 0);
      if (i < 3) exp_bubble("push.bubble", 1);
      else       exp_w("push", 4'h1, 4'hA, 64'h1F8, 64'd0, 4'h4, 4'hF, 1);
    end

    // rmmovq one byte past the last legal address.
    step();
    set_m(4'h1, 4'h4, 64'd8185, 64'h11, 4'hF, 4'hF);
    dif.dmem_ready = 1'b1;
    chk("adr.req",   S_REQ,   64'd0, 0);
    chk("adr.mstat", S_MSTAT, 64'h3, 0);
    chk("adr.stall", S_STALL, 64'd0, 0);
    chk("adr.W_stat",  S_WSTAT,  64'h3, 1);
    chk("adr.W_icode", S_WICODE, 64'h4, 1);

    // halt reaches W.
    step();
    set_m(4'h2, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF);
    chk("hlt.mstat",   S_MSTAT, 64'h2, 0);
    chk("hlt.W_stat",  S_WSTAT, 64'h2, 1);

    // call behind a halted W: no write allowed.
    step();
    set_m(4'h1, 4'h8, 64'h200, 64'h33, 4'h4, 4'hF);
    chk("supp.req",   S_REQ,   64'd0, 0);
    chk("supp.mstat", S_MSTAT, 64'h1, 0);
    chk("supp.W_icode", S_WICODE, 64'h8, 1);

    // mrmovq at the last legal address.
    step();
    set_m(4'h1, 4'h5, 64'd8184, 64'd0, 4'hF, 4'h7);
    dif.dmem_rdata = 64'h1234;
    chk("edge.req",   S_REQ,   64'd1,      0);
    chk("edge.mstat", S_MSTAT, 64'h1,      0);
    chk("edge.valM",  S_VALM,  64'h1234,   0);
    exp_w("edge", 4'h1, 4'h5, 64'd8184, 64'h1234, 4'hF, 4'h7, 1);

    // OPq: no memory access, valM forced to zero.
    step();
    set_m(4'h1, 4'h6, 64'h77, 64'h5, 4'h2, 4'hF);
    dif.dmem_rdata = 64'hFFFF;
    chk("op.req",  S_REQ,  64'd0, 0);
    chk("op.valM", S_VALM, 64'd0, 0);
    exp_w("op", 4'h1, 4'h6, 64'h77, 64'd0, 4'h2, 4'hF, 1);

    // ret reads from M_valA.
    step();
    set_m(4'h1, 4'h9, 64'h300, 64'h208, 4'h4, 4'hF);
    dif.dmem_rdata = 64'h99;
    chk("ret.addr", S_ADDR, 64'h208, 0);
    chk("ret.we",   S_WE,   64'd0,   0);
    chk("ret.valM", S_VALM, 64'h99,  0);
    exp_w("ret", 4'h1, 4'h9, 64'h300, 64'h99, 4'h4, 4'hF, 1);

    // Reset while waiting on a pushq.
    for (int i = 0; i < 2; i++) begin
      step();
      set_m(4'h1, 4'hA, 64'h400, 64'hCC, 4'h4, 4'hF);
      dif.dmem_ready = 1'b0;
      chk("rw.stall", S_STALL, 64'd1, 0);
      exp_bubble("rw.bubble", 1);
    end
    step();
    rst_n = 1'b0;
    chk("rw.req",   S_REQ,   64'd0, 0);
    chk("rw.stall", S_STALL, 64'd0, 0);
    exp_w("rw.reset", 4'h1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 0);
    step();
    rst_n = 1'b1;
    set_m(4'h1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    dif.dmem_ready = 1'b1;
    chk("post.req", S_REQ, 64'd0, 0);

`ifdef MEM_TIMEOUT_EN
    // Ready never comes: 16 WAIT cycles, then abort as ADR.
    for (int i = 0; i <= 16; i++) begin
      step();
      set_m(4'h1, 4'hA, 64'h500, 64'hEE, 4'h4, 4'hF);
      dif.dmem_ready = 1'b0;
      chk("to.req", S_REQ, (i < 16) ? 64'd1 : 64'd0, 0);
      if (i == 16) begin
        chk("to.mstat", S_MSTAT, 64'h3, 0);
        chk("to.W_stat",  S_WSTAT,  64'h3, 1);
        chk("to.W_icode", S_WICODE, 64'hA, 1);
      end
    end
`endif

    step();
    set_m(4'h1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    dif.dmem_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL pending: got %0d unchecked, want 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
